// File: rtl/mips_isa_pkg.sv
// MIPS subset encoding constants shared with the main/ALU decoders, plus the
// symbolic mnemonic set and the word encoder used by the program loader.
package mips_isa_pkg;

    typedef enum logic [3:0] {
        MN_ADD  = 4'd0,
        MN_SUB  = 4'd1,
        MN_AND  = 4'd2,
        MN_OR   = 4'd3,
        MN_SLT  = 4'd4,
        MN_LW   = 4'd5,
        MN_SW   = 4'd6,
        MN_BEQ  = 4'd7,
        MN_ADDI = 4'd8,
        MN_J    = 4'd9
    } instr_mnem_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } loader_state_t;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_result_t;

    // Unused fields per format are simply not placed into the word.
    function automatic enc_result_t encode(
        input logic [3:0]  mnem,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        enc_result_t r;
        r.legal = 1'b1;
        r.word  = '0;
        case (mnem)
            MN_ADD:  r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD};
            MN_SUB:  r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUB};
            MN_AND:  r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_AND};
            MN_OR:   r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_OR};
            MN_SLT:  r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_SLT};
            MN_LW:   r.word = {OP_LW,   rs, rt, imm};
            MN_SW:   r.word = {OP_SW,   rs, rt, imm};
            MN_BEQ:  r.word = {OP_BEQ,  rs, rt, imm};
            MN_ADDI: r.word = {OP_ADDI, rs, rt, imm};
            MN_J:    r.word = {OP_J, target};
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_instr_encode_comb.sv
// Pure combinational encoder: symbolic request in, 32-bit MIPS word and legal flag out.
module mips_instr_encode_comb
    import mips_isa_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    enc_result_t res;

    always_comb begin
        res   = encode(mnem, rs, rt, rd, imm, target);
        word  = res.word;
        legal = res.legal;
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes symbolic requests and streams them into imem through a
// one-entry output stage with an auto-incrementing word address.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned BASE   = 0,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              illegal,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE + DEPTH - 1);

    loader_state_t state;
    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          last_staged;
    logic          req_fire;
    logic          wr_fire;

    mips_instr_encode_comb u_enc (
        .mnem   (in_mnem),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .imm    (in_imm),
        .target (in_target),
        .word   (enc_word),
        .legal  (enc_legal)
    );

    // Once the final slot is staged no further request may enter, even if imem drains it now.
    always_comb begin
        last_staged = wr_valid && (wr_addr == LAST_ADDR);
        in_ready    = (state == ST_RUN) && (!wr_valid || wr_ready) && !last_staged;
        req_fire    = in_valid && in_ready;
        wr_fire     = wr_valid && wr_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wr_valid <= 1'b0;
            wr_addr  <= BASE_ADDR;
            wr_data  <= '0;
            illegal  <= 1'b0;
            full     <= 1'b0;
            count    <= '0;
        end else begin
            illegal <= 1'b0;
            if (clear) begin
                state    <= ST_IDLE;
                wr_valid <= 1'b0;
                wr_addr  <= BASE_ADDR;
                full     <= 1'b0;
                count    <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_FULL: begin
                        if (start) begin
                            state    <= ST_RUN;
                            wr_valid <= 1'b0;
                            wr_addr  <= BASE_ADDR;
                            full     <= 1'b0;
                            count    <= '0;
                        end
                    end
                    ST_RUN: begin
                        // Drain first; a same-cycle accept below refills the stage.
                        if (wr_fire) begin
                            wr_valid <= 1'b0;
                            count    <= count + (ADDR_W+1)'(1);
                            if (wr_addr == LAST_ADDR) begin
                                state <= ST_FULL;
                                full  <= 1'b1;
                            end else begin
                                wr_addr <= wr_addr + ADDR_W'(1);
                            end
                        end
                        if (req_fire) begin
                            if (enc_legal) begin
                                wr_valid <= 1'b1;
                                wr_data  <= enc_word;
                            end else begin
                                illegal <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench: cycle-level behavioural loader model plus directed literal checks.
module tb_mips_instr_encoder;
    import mips_isa_pkg::*;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned BASE   = 0;
    localparam int unsigned DEPTH  = 4;
    localparam int          LAST   = BASE + DEPTH - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_mnem = '0;
    logic [4:0]        in_rs = '0;
    logic [4:0]        in_rt = '0;
    logic [4:0]        in_rd = '0;
    logic [15:0]       in_imm = '0;
    logic [25:0]       in_target = '0;
    logic              wr_valid;
    logic              wr_ready = 1'b0;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              illegal;
    logic              full;
    logic [ADDR_W:0]   count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(ADDR_W), .BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .illegal(illegal), .full(full), .count(count)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference encoder written from the opcode/funct table with plain arithmetic.
    function automatic void ref_encode(input int m, input int rs, input int rt, input int rd,
                                       input int imm, input int tgt,
                                       output bit ok, output logic [31:0] w);
        longint unsigned v;
        int op;
        int fn;
        ok = 1'b1; op = 0; fn = 0;
        case (m)
            0: fn = 32;  1: fn = 34;  2: fn = 36;  3: fn = 37;  4: fn = 42;
            5: op = 35;  6: op = 43;  7: op = 4;   8: op = 8;   9: op = 2;
            default: ok = 1'b0;
        endcase
        if (m <= 4)
            v = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + fn;
        else if (m == 9)
            v = op * 64'd67108864 + tgt;
        else
            v = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
        w = v[31:0];
    endfunction

    // Loader model: loading = accepting requests, done = memory filled, holding = word waiting for imem.
    bit          m_loading, m_done, m_holding, m_bad, m_take, r_ok;
    logic [31:0] m_word, r_w;
    int          m_slot = BASE;
    int          m_written = 0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_loading = 0; m_done = 0; m_holding = 0; m_bad = 0;
                m_slot = BASE; m_written = 0;
            end else begin
                m_take = m_loading && in_valid && (!m_holding || wr_ready)
                         && !(m_holding && m_slot == LAST);
                ref_encode(int'(in_mnem), int'(in_rs), int'(in_rt), int'(in_rd),
                           int'(in_imm), int'(in_target), r_ok, r_w);
                m_bad = 0;
                if (clear) begin
                    m_loading = 0; m_done = 0; m_holding = 0;
                    m_slot = BASE; m_written = 0;
                end else if (!m_loading) begin
                    if (start) begin
                        m_loading = 1; m_done = 0; m_holding = 0;
                        m_slot = BASE; m_written = 0;
                    end
                end else begin
                    if (m_holding && wr_ready) begin
                        m_written++;
                        m_holding = 0;
                        if (m_slot == LAST) begin m_loading = 0; m_done = 1; end
                        else m_slot++;
                    end
                    if (m_take) begin
                        if (r_ok) begin m_holding = 1; m_word = r_w; end
                        else m_bad = 1;
                    end
                end
            end
        end
    end

    int          n_illegal = 0;
    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];

    always @(negedge clk) begin
        bit exp_rdy;
        exp_rdy = m_loading && (!m_holding || wr_ready) && !(m_holding && m_slot == LAST);
        check("in_ready", in_ready, exp_rdy);
        check("wr_valid", wr_valid, m_holding);
        check("wr_addr", wr_addr, m_slot);
        check("illegal", illegal, m_bad);
        check("full", full, m_done);
        check("count", count, m_written);
        if (m_holding) check("wr_data", wr_data, m_word);
        if (reset_n && wr_valid && wr_ready) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (illegal) n_illegal++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic send(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input int budget, output bit ok);
        bit hs;
        in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            if (hs) ok = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_log(input string name, input int idx, input int addr, input logic [31:0] data);
        check({name, "_logged"}, (log_addr.size() > idx) ? 1 : 0, 1);
        if (log_addr.size() > idx) begin
            check({name, "_addr"}, log_addr[idx], addr);
            check({name, "_data"}, log_data[idx], data);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int b;
        int ill0;
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'h01095020; exp_seq[1] = 32'h8FA80004;
        exp_seq[2] = 32'h1109FFFF; exp_seq[3] = 32'h08000040;

        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_wr_valid", wr_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_illegal", illegal, 0);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_wr_addr", wr_addr, BASE);
        check("rst_wr_data", wr_data, 0);
        reset_n = 1'b1;
        wr_ready = 1'b1;
        tick();

        // ADDI one cycle after accept
        pulse_start();
        send(MN_ADDI, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0, 20, ok);
        check("addi_accept", ok, 1);
        @(negedge clk);
        check("addi_valid", wr_valid, 1);
        check("addi_addr", wr_addr, 0);
        check("addi_data", wr_data, 32'h20080005);
        tick();
        tick();

        // Fill DEPTH=4 then offer a fifth request
        pulse_clear();
        pulse_start();
        b = log_addr.size();
        send(MN_ADD, 5'd8, 5'd9, 5'd10, 16'd0, 26'd0, 20, ok);      check("add_accept", ok, 1);
        send(MN_LW, 5'd29, 5'd8, 5'd0, 16'd4, 26'd0, 20, ok);       check("lw_accept", ok, 1);
        send(MN_BEQ, 5'd8, 5'd9, 5'd0, 16'hFFFF, 26'd0, 20, ok);    check("beq_accept", ok, 1);
        send(MN_J, 5'd0, 5'd0, 5'd0, 16'd0, 26'h40, 20, ok);        check("j_accept", ok, 1);
        send(MN_ADDI, 5'd1, 5'd2, 5'd0, 16'd3, 26'd0, 10, ok);      check("fifth_rejected", ok, 0);
        tick();
        check("full_after4", full, 1);
        check("count_after4", count, 4);
        check("addr_hold_last", wr_addr, LAST);
        for (int i = 0; i < 4; i++) check_log("seq", b + i, i, exp_seq[i]);
        check("seq_nwrites", log_addr.size() - b, 4);

        // Backpressure: wr_ready low 3 cycles
        pulse_clear();
        pulse_start();
        b = log_addr.size();
        wr_ready = 1'b0;
        send(MN_ADDI, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0, 20, ok);
        check("stall_first_accept", ok, 1);
        in_mnem = MN_SUB; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_wr_valid", wr_valid, 1);
            check("stall_wr_addr", wr_addr, 0);
            check("stall_wr_data", wr_data, 32'h20080005);
            @(posedge clk); #1;
        end
        wr_ready = 1'b1;
        send(MN_SUB, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 20, ok);
        check("stall_second_accept", ok, 1);
        repeat (3) tick();
        check_log("stall0", b, 0, 32'h20080005);
        check_log("stall1", b + 1, 1, 32'h00221822);
        check("stall_count", count, 2);

        // Illegal mnemonic between two ADDIs
        pulse_clear();
        pulse_start();
        b = log_addr.size();
        ill0 = n_illegal;
        send(MN_ADDI, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0, 20, ok);  check("ill_a_accept", ok, 1);
        send(4'hF, 5'd3, 5'd3, 5'd3, 16'd3, 26'd3, 20, ok);       check("ill_accept", ok, 1);
        send(MN_ADDI, 5'd8, 5'd9, 5'd0, 16'd7, 26'd0, 20, ok);  check("ill_b_accept", ok, 1);
        repeat (3) tick();
        check("ill_pulses", n_illegal - ill0, 1);
        check("ill_count", count, 2);
        check_log("ill0", b, 0, 32'h20080005);
        check_log("ill1", b + 1, 1, 32'h21090007);

        // Asynchronous reset mid-RUN with a staged word
        pulse_clear();
        pulse_start();
        wr_ready = 1'b0;
        send(MN_ADDI, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0, 20, ok);
        check("ar_accept", ok, 1);
        check("ar_pre_valid", wr_valid, 1);
        reset_n = 1'b0;
        #1;
        check("ar_wr_valid", wr_valid, 0);
        check("ar_in_ready", in_ready, 0);
        check("ar_count", count, 0);
        check("ar_wr_addr", wr_addr, BASE);
        check("ar_wr_data", wr_data, 0);
        check("ar_full", full, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Randomized traffic against the model
        pulse_start();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mnem   = 4'($urandom_range(0, 15));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_imm    = 16'($urandom);
            in_target = 26'($urandom);
            wr_ready  = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 15) == 0);
            clear     = ($urandom_range(0, 63) == 0);
            tick();
        end
        in_valid = 1'b0; start = 1'b0; clear = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
